// File: rtl/vm_vend_ctrl_pkg.sv
// Shared types for the vending controller: coin and status codes, the one-hot
// controller state with its bit-index enum, and coin value decoding.
package vm_vend_ctrl_pkg;

    localparam int unsigned COIN_UNITS_W = 3;

    typedef enum logic [1:0] {
        NO_COINS = 2'd0,
        NICKEL   = 2'd1,
        DIME     = 2'd2,
        QUARTER  = 2'd3
    } coins_t;

    typedef enum logic [1:0] {
        NO_STATUS    = 2'd0,
        AVAILABE     = 2'd1,
        OUT_OF_STOCK = 2'd2,
        ERROR        = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        IDLE_I     = 3'd0,
        COLLECT_I  = 3'd1,
        CHECK_I    = 3'd2,
        DISPENSE_I = 3'd3,
        CHANGE_I   = 3'd4
    } vm_ctrl_state_idx_t;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        COLLECT  = 5'b00010,
        CHECK    = 5'b00100,
        DISPENSE = 5'b01000,
        CHANGE   = 5'b10000
    } vm_ctrl_state_t;

    // Coin value in nickel units.
    function automatic logic [COIN_UNITS_W-1:0] coin_units(coins_t c);
        case (c)
            NICKEL:  return 3'd1;
            DIME:    return 3'd2;
            QUARTER: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_item_table.sv
// Per-slot price and stock storage: one config write port, one combinational
// read port and one stock decrement port.
module vm_item_table
    import vm_vend_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 8,
    parameter int unsigned COUNT_W   = 4,
    parameter int unsigned CREDIT_W  = 8,
    localparam int unsigned IW       = $clog2(NUM_ITEMS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_item,
    input  logic [CREDIT_W-1:0] cfg_cost,
    input  logic [COUNT_W-1:0]  cfg_count,
    input  logic [IW-1:0]       rd_item,
    output logic [CREDIT_W-1:0] rd_cost_c,
    output logic [COUNT_W-1:0]  rd_count_c,
    input  logic                dec_en,
    input  logic [IW-1:0]       dec_item
);

    logic [CREDIT_W-1:0] cost_q  [NUM_ITEMS];
    logic [COUNT_W-1:0]  count_q [NUM_ITEMS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                cost_q[IW'(i)]  <= '0;
                count_q[IW'(i)] <= '0;
            end
        end else begin
            if (cfg_we && (32'(cfg_item) < NUM_ITEMS)) begin
                cost_q[cfg_item]  <= cfg_cost;
                count_q[cfg_item] <= cfg_count;
            end
            if (dec_en && (32'(dec_item) < NUM_ITEMS)) begin
                count_q[dec_item] <= count_q[dec_item] - COUNT_W'(1);
            end
        end
    end

    // Out-of-range slots read as empty and free.
    always_comb begin
        rd_cost_c  = '0;
        rd_count_c = '0;
        if (32'(rd_item) < NUM_ITEMS) begin
            rd_cost_c  = cost_q[rd_item];
            rd_count_c = count_q[rd_item];
        end
    end

endmodule

// File: rtl/vm_vend_ctrl.sv
// Vending machine controller: coin collection, product selection against the
// item table, single-cycle dispense pulse and greedy coin change.
module vm_vend_ctrl
    import vm_vend_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 8,
    parameter int unsigned COUNT_W   = 4,
    parameter int unsigned CREDIT_W  = 8,
    localparam int unsigned IW       = $clog2(NUM_ITEMS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                select_valid,
    input  logic [IW-1:0]       select,
    input  logic                cancel,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_item,
    input  logic [CREDIT_W-1:0] cfg_cost,
    input  logic [COUNT_W-1:0]  cfg_count,
    output logic                coin_reject,
    output logic                dispense_valid,
    output logic [IW-1:0]       dispense_item,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          status,
    output logic                busy
);

    localparam int unsigned SUM_W = CREDIT_W + 3;

    vm_ctrl_state_t      state, state_d;
    status_t             status_d;
    coins_t              change_coin_d, chg_coin_c;
    logic [CREDIT_W-1:0] credit_d, credit_acc_c, cost_c;
    logic [COUNT_W-1:0]  count_c;
    logic [IW-1:0]       sel_q, sel_d, dispense_item_d;
    logic                coin_reject_d, dispense_valid_d, change_valid_d, busy_d;
    logic                tbl_we_c, dec_en_c, coin_ok_c;
    logic [SUM_W-1:0]    credit_ext_c, coin_sum_c;

    vm_item_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .COUNT_W   (COUNT_W),
        .CREDIT_W  (CREDIT_W)
    ) u_item_table (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (tbl_we_c),
        .cfg_item   (cfg_item),
        .cfg_cost   (cfg_cost),
        .cfg_count  (cfg_count),
        .rd_item    (sel_q),
        .rd_cost_c  (cost_c),
        .rd_count_c (count_c),
        .dec_en     (dec_en_c),
        .dec_item   (sel_q)
    );

    // Coin acceptance against saturation, and greedy change coin choice.
    always_comb begin
        credit_ext_c = SUM_W'(credit);
        coin_sum_c   = credit_ext_c + SUM_W'(coin_units(coins_t'(coin)));
        coin_ok_c    = coin_valid && (coins_t'(coin) != NO_COINS) &&
                       (coin_sum_c[SUM_W-1:CREDIT_W] == '0);
        credit_acc_c = coin_ok_c ? coin_sum_c[CREDIT_W-1:0] : credit;
        chg_coin_c   = (credit_ext_c >= SUM_W'(5)) ? QUARTER :
                       (credit_ext_c >= SUM_W'(2)) ? DIME : NICKEL;
    end

    always_comb begin
        state_d          = state;
        credit_d         = credit;
        status_d         = status_t'(status);
        sel_d            = sel_q;
        coin_reject_d    = 1'b0;
        dispense_valid_d = 1'b0;
        dispense_item_d  = dispense_item;
        change_valid_d   = 1'b0;
        change_coin_d    = coins_t'(change_coin);
        tbl_we_c         = 1'b0;
        dec_en_c         = 1'b0;
        case (state)
            IDLE: begin
                tbl_we_c = cfg_we;
                credit_d = credit_acc_c;
                if (coin_valid) begin
                    if (coin_ok_c) begin
                        state_d = COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                        status_d      = ERROR;
                    end
                end
            end
            COLLECT: begin
                credit_d = credit_acc_c;
                if (coin_valid && !coin_ok_c) begin
                    coin_reject_d = 1'b1;
                    status_d      = ERROR;
                end
                // Select sees the credit including this cycle's coin.
                if (cancel) begin
                    state_d = (credit_acc_c != '0) ? CHANGE : IDLE;
                end else if (select_valid) begin
                    if (32'(select) >= NUM_ITEMS) begin
                        status_d = ERROR;
                    end else begin
                        sel_d   = select;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                coin_reject_d = coin_valid;
                if (count_c == '0) begin
                    status_d = OUT_OF_STOCK;
                    state_d  = COLLECT;
                end else if (credit < cost_c) begin
                    status_d = ERROR;
                    state_d  = COLLECT;
                end else begin
                    credit_d         = credit - cost_c;
                    dec_en_c         = 1'b1;
                    status_d         = AVAILABE;
                    dispense_valid_d = 1'b1;
                    dispense_item_d  = sel_q;
                    state_d          = DISPENSE;
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_valid;
                state_d       = (credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                if (credit == '0) begin
                    state_d = IDLE;
                end else begin
                    change_valid_d = 1'b1;
                    change_coin_d  = chg_coin_c;
                    credit_d       = credit - CREDIT_W'(coin_units(chg_coin_c));
                    if (credit_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign busy_d = state_d[CHECK_I] | state_d[DISPENSE_I] | state_d[CHANGE_I];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            credit         <= '0;
            status         <= NO_STATUS;
            sel_q          <= '0;
            coin_reject    <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            change_valid   <= 1'b0;
            change_coin    <= NO_COINS;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            credit         <= credit_d;
            status         <= status_d;
            sel_q          <= sel_d;
            coin_reject    <= coin_reject_d;
            dispense_valid <= dispense_valid_d;
            dispense_item  <= dispense_item_d;
            change_valid   <= change_valid_d;
            change_coin    <= change_coin_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_vm_vend_ctrl.sv
// Bench for vm_vend_ctrl: directed vector table, hand sequences on a small
// configuration, and random traffic against a transaction-level model.
module tb_vm_vend_ctrl;
    import vm_vend_ctrl_pkg::*;

    localparam int K_NONE = 0, K_COIN = 1, K_SEL = 2, K_CAN = 3, K_CFG = 4;
    localparam int PH_IDLE = 0, PH_COLL = 1, PH_CHECK = 2, PH_DISP = 3, PH_CHG = 4;
    localparam int NS = int'(NO_STATUS), AV = int'(AVAILABE);
    localparam int OS = int'(OUT_OF_STOCK), ER = int'(ERROR);
    localparam int CN = int'(NICKEL), CD = int'(DIME), CQ = int'(QUARTER);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, coin_valid, select_valid, cancel, cfg_we;
    logic [1:0] coin;
    logic [2:0] select, cfg_item;
    logic [7:0] cfg_cost;
    logic [3:0] cfg_count;
    logic       coin_reject, dispense_valid, change_valid, busy;
    logic [2:0] dispense_item;
    logic [1:0] change_coin, status;
    logic [7:0] credit;

    logic       s_reset, s_coin_valid, s_select_valid, s_cancel, s_cfg_we;
    logic [1:0] s_coin;
    logic [2:0] s_select, s_cfg_item;
    logic [3:0] s_cfg_cost, s_cfg_count;
    logic       s_coin_reject, s_dispense_valid, s_change_valid, s_busy;
    logic [2:0] s_dispense_item;
    logic [1:0] s_change_coin, s_status;
    logic [3:0] s_credit;

    vm_vend_ctrl dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
        .select_valid(select_valid), .select(select), .cancel(cancel),
        .cfg_we(cfg_we), .cfg_item(cfg_item), .cfg_cost(cfg_cost), .cfg_count(cfg_count),
        .coin_reject(coin_reject), .dispense_valid(dispense_valid),
        .dispense_item(dispense_item), .change_valid(change_valid),
        .change_coin(change_coin), .credit(credit), .status(status), .busy(busy)
    );

    vm_vend_ctrl #(.NUM_ITEMS(6), .COUNT_W(4), .CREDIT_W(4)) dut6 (
        .clk(clk), .reset(s_reset), .coin_valid(s_coin_valid), .coin(s_coin),
        .select_valid(s_select_valid), .select(s_select), .cancel(s_cancel),
        .cfg_we(s_cfg_we), .cfg_item(s_cfg_item), .cfg_cost(s_cfg_cost), .cfg_count(s_cfg_count),
        .coin_reject(s_coin_reject), .dispense_valid(s_dispense_valid),
        .dispense_item(s_dispense_item), .change_valid(s_change_valid),
        .change_coin(s_change_coin), .credit(s_credit), .status(s_status), .busy(s_busy)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int kind, a, b, c;
        int cr, st, bz, dv, item, cv, cn, rj;
    } vec_t;
    vec_t vecs[$];

    // Reference model state
    int m_credit, m_status, m_ph, m_sel;
    int m_cost[8];
    int m_cnt[8];
    int m_q[$];
    int e_rej, e_dv, e_item, e_cv, e_cn, e_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        coin_valid = 0; coin = 0; select_valid = 0; select = 0; cancel = 0;
        cfg_we = 0; cfg_item = 0; cfg_cost = 0; cfg_count = 0;
    endtask

    task automatic s_clr();
        s_coin_valid = 0; s_coin = 0; s_select_valid = 0; s_select = 0; s_cancel = 0;
        s_cfg_we = 0; s_cfg_item = 0; s_cfg_cost = 0; s_cfg_count = 0;
    endtask

    task automatic apply(input int kind, input int a, input int b, input int c);
        clr_in();
        case (kind)
            K_COIN: begin coin_valid = 1; coin = 2'(a); end
            K_SEL:  begin select_valid = 1; select = 3'(a); end
            K_CAN:  cancel = 1;
            K_CFG:  begin cfg_we = 1; cfg_item = 3'(a); cfg_cost = 8'(b); cfg_count = 4'(c); end
            default: ;
        endcase
    endtask

    task automatic chk_out(input string t, input int cr, input int st, input int bz,
                           input int dv, input int item, input int cv, input int cn, input int rj);
        chk({t, " credit"}, 32'(credit), cr);
        chk({t, " status"}, 32'(status), st);
        chk({t, " busy"}, 32'(busy), bz);
        chk({t, " dispense_valid"}, 32'(dispense_valid), dv);
        chk({t, " change_valid"}, 32'(change_valid), cv);
        chk({t, " coin_reject"}, 32'(coin_reject), rj);
        if (dv != 0) chk({t, " dispense_item"}, 32'(dispense_item), item);
        if (cv != 0) chk({t, " change_coin"}, 32'(change_coin), cn);
    endtask

    function automatic void add(int kind, int a, int b, int c, int cr, int st, int bz,
                                int dv, int item, int cv, int cn, int rj);
        vec_t v;
        v.kind = kind; v.a = a; v.b = b; v.c = c;
        v.cr = cr; v.st = st; v.bz = bz; v.dv = dv; v.item = item;
        v.cv = cv; v.cn = cn; v.rj = rj;
        vecs.push_back(v);
    endfunction

    function automatic void start_refund();
        int r = m_credit;
        m_q.delete();
        while (r > 0) begin
            if (r >= 5) begin m_q.push_back(CQ); r -= 5; end
            else if (r >= 2) begin m_q.push_back(CD); r -= 2; end
            else begin m_q.push_back(CN); r -= 1; end
        end
        m_ph = PH_CHG;
    endfunction

    function automatic int units(int c);
        return (c == CN) ? 1 : (c == CD) ? 2 : (c == CQ) ? 5 : 0;
    endfunction

    // One cycle of the vending rules as a transaction model.
    task automatic model_step(input int cv, input int c, input int sv, input int sel,
                              input int can, input int we, input int it, input int cst, input int cnt);
        int u;
        int was_idle;
        int k;
        e_rej = 0; e_dv = 0; e_cv = 0;
        u = units(c);
        if (m_ph == PH_IDLE || m_ph == PH_COLL) begin
            was_idle = (m_ph == PH_IDLE) ? 1 : 0;
            if (was_idle != 0 && we != 0) begin m_cost[it] = cst; m_cnt[it] = cnt; end
            if (cv != 0) begin
                if (u == 0 || m_credit + u > 255) begin e_rej = 1; m_status = ER; end
                else begin m_credit += u; m_ph = PH_COLL; end
            end
            if (was_idle == 0) begin
                if (can != 0) begin
                    if (m_credit > 0) start_refund(); else m_ph = PH_IDLE;
                end else if (sv != 0) begin
                    if (sel >= 8) m_status = ER;
                    else begin m_sel = sel; m_ph = PH_CHECK; end
                end
            end
        end else begin
            if (cv != 0) e_rej = 1;
            case (m_ph)
                PH_CHECK: begin
                    if (m_cnt[m_sel] == 0) begin m_status = OS; m_ph = PH_COLL; end
                    else if (m_credit < m_cost[m_sel]) begin m_status = ER; m_ph = PH_COLL; end
                    else begin
                        m_credit -= m_cost[m_sel];
                        m_cnt[m_sel] -= 1;
                        m_status = AV;
                        e_dv = 1; e_item = m_sel;
                        m_ph = PH_DISP;
                    end
                end
                PH_DISP: begin
                    if (m_credit > 0) start_refund(); else m_ph = PH_IDLE;
                end
                default: begin
                    k = m_q.pop_front();
                    m_credit -= units(k);
                    e_cv = 1; e_cn = k;
                    if (m_q.size() == 0) m_ph = PH_IDLE;
                end
            endcase
        end
        e_busy = (m_ph >= PH_CHECK) ? 1 : 0;
    endtask

    initial begin
        clr_in();
        s_clr();
        reset = 1; s_reset = 1;
        repeat (2) step();
        reset = 0; s_reset = 0;
        chk_out("reset", 0, NS, 0, 0, 0, 0, 0, 0);

        // kind, a, b, c | credit, status, busy, dv, item, cv, coin, reject
        add(K_CFG, 1, 10, 2,  0, NS, 0, 0, 0, 0, 0, 0);
        add(K_CFG, 3, 4, 0,   0, NS, 0, 0, 0, 0, 0, 0);
        add(K_CFG, 2, 10, 5,  0, NS, 0, 0, 0, 0, 0, 0);
        add(K_COIN, CQ, 0, 0, 5, NS, 0, 0, 0, 0, 0, 0);
        add(K_COIN, CQ, 0, 0, 10, NS, 0, 0, 0, 0, 0, 0);
        add(K_SEL, 1, 0, 0,   10, NS, 1, 0, 0, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  0, AV, 1, 1, 1, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  0, AV, 0, 0, 0, 0, 0, 0);
        add(K_COIN, CQ, 0, 0, 5, AV, 0, 0, 0, 0, 0, 0);
        add(K_COIN, CQ, 0, 0, 10, AV, 0, 0, 0, 0, 0, 0);
        add(K_COIN, CQ, 0, 0, 15, AV, 0, 0, 0, 0, 0, 0);
        add(K_SEL, 1, 0, 0,   15, AV, 1, 0, 0, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  5, AV, 1, 1, 1, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  5, AV, 1, 0, 0, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  0, AV, 0, 0, 0, 1, CQ, 0);
        add(K_COIN, CD, 0, 0, 2, AV, 0, 0, 0, 0, 0, 0);
        add(K_SEL, 3, 0, 0,   2, AV, 1, 0, 0, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  2, OS, 0, 0, 0, 0, 0, 0);
        add(K_CAN, 0, 0, 0,   2, OS, 1, 0, 0, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  0, OS, 0, 0, 0, 1, CD, 0);
        add(K_COIN, CN, 0, 0, 1, OS, 0, 0, 0, 0, 0, 0);
        add(K_CFG, 2, 1, 5,   1, OS, 0, 0, 0, 0, 0, 0);
        add(K_SEL, 2, 0, 0,   1, OS, 1, 0, 0, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  1, ER, 0, 0, 0, 0, 0, 0);
        add(K_SEL, 1, 0, 0,   1, ER, 1, 0, 0, 0, 0, 0);
        add(K_COIN, CQ, 0, 0, 1, OS, 0, 0, 0, 0, 0, 1);
        add(K_CAN, 0, 0, 0,   1, OS, 1, 0, 0, 0, 0, 0);
        add(K_NONE, 0, 0, 0,  0, OS, 0, 0, 0, 1, CN, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].kind, vecs[i].a, vecs[i].b, vecs[i].c);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].cr, vecs[i].st, vecs[i].bz, vecs[i].dv,
                    vecs[i].item, vecs[i].cv, vecs[i].cn, vecs[i].rj);
        end

        // Reset arriving while change of 7 is pending.
        apply(K_COIN, CQ, 0, 0); step();
        apply(K_COIN, CD, 0, 0); step();
        apply(K_CAN, 0, 0, 0);   step();
        chk_out("chg7", 7, OS, 1, 0, 0, 0, 0, 0);
        clr_in();
        reset = 1; step(); reset = 0;
        chk_out("rst_chg", 0, NS, 0, 0, 0, 0, 0, 0);
        step();
        chk_out("rst_idle", 0, NS, 0, 0, 0, 0, 0, 0);

        // Saturation on a 4-bit credit register.
        s_coin_valid = 1;
        s_coin = 2'(CQ); step();
        s_coin = 2'(CQ); step();
        s_coin = 2'(CD); step();
        chk("sat credit12", 32'(s_credit), 12);
        s_coin = 2'(CQ); step();
        chk("sat reject", 32'(s_coin_reject), 1);
        chk("sat credit", 32'(s_credit), 12);
        chk("sat status", 32'(s_status), ER);
        s_coin = 2'(CD); step();
        chk("sat d reject", 32'(s_coin_reject), 0);
        s_coin = 2'(CN); step();
        chk("sat max credit", 32'(s_credit), 15);
        chk("sat max reject", 32'(s_coin_reject), 0);
        s_coin = 2'(CN); step();
        chk("sat n reject", 32'(s_coin_reject), 1);
        chk("sat n credit", 32'(s_credit), 15);

        // Slot index beyond a six-slot machine.
        s_clr();
        s_reset = 1; step(); s_reset = 0;
        chk("s reset status", 32'(s_status), NS);
        s_coin_valid = 1; s_coin = 2'(CQ); step();
        s_clr();
        s_select_valid = 1; s_select = 3'd7; step();
        s_clr();
        chk("bad slot status", 32'(s_status), ER);
        chk("bad slot busy", 32'(s_busy), 0);
        chk("bad slot credit", 32'(s_credit), 5);
        step();
        chk("bad slot stays", 32'(s_busy), 0);

        // Random traffic against the model.
        clr_in();
        reset = 1; step(); reset = 0;
        m_credit = 0; m_status = NS; m_ph = PH_IDLE; m_sel = 0; m_q.delete();
        for (int i = 0; i < 8; i++) begin m_cost[i] = 0; m_cnt[i] = 0; end
        for (int n = 0; n < 3000; n++) begin
            int cv, c, sv, sel, can, we, it, cst, cnt;
            cv = (($urandom % 10) < 4) ? 1 : 0;
            c = int'($urandom % 4);
            sv = (($urandom % 10) < 2) ? 1 : 0;
            sel = int'($urandom % 8);
            can = (($urandom % 40) == 0) ? 1 : 0;
            we = (($urandom % 5) == 0) ? 1 : 0;
            it = int'($urandom % 8);
            cst = int'($urandom % 31);
            cnt = int'($urandom % 4);
            clr_in();
            coin_valid = cv[0]; coin = 2'(c); select_valid = sv[0]; select = 3'(sel);
            cancel = can[0]; cfg_we = we[0]; cfg_item = 3'(it);
            cfg_cost = 8'(cst); cfg_count = 4'(cnt);
            model_step(cv, c, sv, sel, can, we, it, cst, cnt);
            step();
            chk_out("rnd", m_credit, m_status, e_busy, e_dv, e_item, e_cv, e_cn, e_rej);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
